// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the default watchdog limit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    EX_WAIT  = 2'd2,
    HALT     = 2'd3
  } hcu_state_e;

  localparam int DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters.
// It holds at all-ones and ignores increments while frozen.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         freeze,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !freeze && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipe: resolves load-use, redirect,
// memory-wait and multi-cycle EX hazards, with a stall watchdog and perf counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read_id_ex,
  input  logic [4:0]       rd_id_ex,
  input  logic [4:0]       rs1_if_id,
  input  logic [4:0]       rs2_if_id,
  input  logic             use_rs1_if_id,
  input  logic             use_rs2_if_id,
  input  logic             branch_taken_ex,
  input  logic             ex_busy,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int              WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  hcu_state_e      state_q, state_d;
  logic [WD_W-1:0] wd_cnt;
  logic            mem_stall, load_use, any_stall, branch_sel;

  assign mem_stall = dmem_req_mem & ~dmem_ready;
  assign load_use  = mem_read_id_ex & (rd_id_ex != 5'd0) &
                     ((use_rs1_if_id & (rs1_if_id == rd_id_ex)) |
                      (use_rs2_if_id & (rs2_if_id == rd_id_ex)));
  assign any_stall = mem_stall | ex_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Counts consecutive stall cycles; any non-stall cycle restarts the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state_q != HALT) begin
      wd_cnt <= any_stall ? wd_cnt + WD_W'(1) : '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    branch_sel   = 1'b0;
    if (reset || (state_q == HALT)) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else begin
      if (mem_stall) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_flush = 1'b1;
      end else if (ex_busy) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
      end else if (branch_taken_ex) begin
        // A dependent load-use consumer is squashed here, so no bubble is needed.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        branch_sel  = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end

      if (any_stall && (wd_cnt == WD_LAST)) begin
        state_d = HALT;
      end else if (mem_stall) begin
        state_d = MEM_WAIT;
      end else if (ex_busy) begin
        state_d = EX_WAIT;
      end else begin
        state_d = RUN;
      end
    end
  end

  assign state  = state_q;
  assign halted = (state_q == HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (~pc_write),
    .freeze (halted),
    .count  (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (branch_sel),
    .freeze (halted),
    .count  (flush_count)
  );

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and stall controller for the 5-stage RISC-V core. It works alongside `forwarding_unit` and covers the hazards forwarding cannot resolve: load-use, taken branch/jump redirect, multi-cycle memory waits and multi-cycle EX operations. It drives write-enable and flush controls for the PC and every pipeline register. A watchdog stops the pipe if a stall never ends, and saturating counters record stall and flush activity for performance checks.

## Interface
Parameters:
- `TIMEOUT`, 256: number of consecutive stall cycles after which the block enters HALT.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `mem_read_id_ex`  in  1  the instruction in ID/EX is a load.
- `rd_id_ex`  in  5  destination register of the instruction in ID/EX.
- `rs1_if_id`, `rs2_if_id`  in  5  source registers of the instruction in IF/ID.
- `use_rs1_if_id`, `use_rs2_if_id`  in  1  the instruction in IF/ID actually reads that source register.
- `branch_taken_ex`  in  1  the branch or jump in EX has resolved as taken.
- `ex_busy`  in  1  a multi-cycle EX operation has not finished.
- `dmem_req_mem`  in  1  the instruction in MEM is accessing data memory.
- `dmem_ready`  in  1  the data memory access completes this cycle.
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write`  out  1  register enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush`  out  1  insert a bubble into that register.
- `halted`  out  1  the watchdog has expired.
- `state`  out  2  current FSM state.
- `stall_cycles`, `flush_count`  out  CNT_W  performance counters.

## Operation
- FSM states: RUN=0, MEM_WAIT=1, EX_WAIT=2, HALT=3. The state records the stall reason. In RUN, MEM_WAIT and EX_WAIT, the control outputs are decoded combinationally from the current inputs.
- Hazard terms:
  - mem_stall = `dmem_req_mem & ~dmem_ready`.
  - load_use = `mem_read_id_ex & (rd_id_ex!=0) & ((use_rs1_if_id & rs1_if_id==rd_id_ex) | (use_rs2_if_id & rs2_if_id==rd_id_ex))`.
- Default: every `*_write`=1 and every `*_flush`=0. The first matching case below applies, in priority order:
  1. mem_stall: all four `*_write`=0 and `mem_wb_flush`=1.
  2. ex_busy: `pc_write`, `if_id_write` and `id_ex_write`=0; `ex_mem_flush`=1.
  3. branch_taken_ex: `if_id_flush`=1 and `id_ex_flush`=1; `pc_write`=1 so the PC loads the target.
  4. load_use: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1.
- A branch and a load-use in the same cycle are handled as a branch, because the dependent instruction is flushed.
- Next state: HALT if the watchdog expires; otherwise MEM_WAIT on mem_stall, else EX_WAIT on ex_busy, else RUN.
- Watchdog (`wd_cnt`):
  - Increments on each cycle with mem_stall or ex_busy, and clears on any other cycle.
  - When a stall cycle occurs with `wd_cnt==TIMEOUT-1`, the next state is HALT.
- HALT is sticky until `reset`. In HALT all `*_write`=0, all `*_flush`=0, `halted`=1, and the counters freeze.
- `stall_cycles` increments on each non-HALT cycle with `pc_write`=0.
- `flush_count` increments on each cycle where case 3 is selected.
- Both counters saturate at all-ones.

## Timing
- While `reset`=1: `state`=RUN, counters=0, `wd_cnt`=0, `halted`=0, all `*_write`=0, all `*_flush`=0.
- The first cycle after reset deasserts uses normal decode.
- Control outputs have zero-cycle latency from the inputs; `state`, `halted` and the counters update at the next edge.
- A load-use costs exactly one bubble: after the bubble the load has moved to MEM, so the hazard term drops on its own.
- A mem_stall of N cycles gives N frozen cycles. Unfreeze happens in the cycle `dmem_ready`=1.
- Reset asserted mid-stall or in HALT returns the block to RUN immediately (asynchronous).

## Structure
- `hazard_pkg` holds the state encoding constants (RUN/MEM_WAIT/EX_WAIT/HALT) and the default `TIMEOUT`.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `reset`, `inc`, `freeze`, `count`) is instantiated twice, once per performance counter.

## Test plan
- Load-use: `mem_read_id_ex`=1, `rd_id_ex`=5, `rs1_if_id`=5, `use_rs1_if_id`=1 for one cycle -> `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1; `stall_cycles`=1 next cycle.
- `rd_id_ex`=0 with a matching `rs1_if_id`=0 -> no stall; `rs2_if_id` matching but `use_rs2_if_id`=0 -> no stall.
- Taken branch together with load-use -> `if_id_flush`=1, `id_ex_flush`=1, `pc_write`=1; `flush_count` +1.
- `dmem_req_mem`=1 with `dmem_ready`=0 for 3 cycles, then 1 -> 3 cycles with all writes 0 and `mem_wb_flush`=1; `state`=MEM_WAIT; back to RUN after `dmem_ready`.
- `TIMEOUT`=4, `ex_busy` held high -> `state`=HALT and `halted`=1 after the 4th stall cycle; all outputs stay 0 until `reset`.
- Async `reset` pulse during MEM_WAIT -> `state`=RUN and all counters 0 with no clock edge.
